// File: rtl/huff_bit_decoder.sv
// Serial Huffman bitstream decoder: matches accumulated code bits against a
// programmable {char, code, len} table and pulses the decoded character ID.
module huff_bit_decoder #(
    parameter  int NUM_CHAR = 8,
    parameter  int CHAR_W   = 4,
    parameter  int CODE_W   = 7,
    localparam int SLOT_W   = $clog2(NUM_CHAR),
    localparam int LEN_W    = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_valid,
    input  logic [SLOT_W-1:0] tbl_slot,
    input  logic [CHAR_W-1:0] tbl_char,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic [LEN_W-1:0]  tbl_len,
    input  logic              tbl_clr,
    input  logic              flush,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    output logic              err,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_DECODE = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(CODE_W);

    // Ones in the low len bits; code bits above the codeword length never take part in a compare.
    function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [CODE_W-1:0] m;
        for (int b = 0; b < CODE_W; b++) begin
            m[b] = (b < int'(len));
        end
        return m;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic                slot_valid_r [NUM_CHAR];
    logic [CHAR_W-1:0]   char_r       [NUM_CHAR];
    logic [CODE_W-1:0]   code_r       [NUM_CHAR];
    logic [LEN_W-1:0]    len_r        [NUM_CHAR];
    logic [CODE_W-1:0]   acc_r;
    logic [LEN_W-1:0]    cnt_r;
    logic                out_valid_r;
    logic [CHAR_W-1:0]   out_char_r;
    logic                err_r;
    logic                busy_r;

    logic                any_valid_next_s;
    logic                take_bit_s;
    logic [CODE_W-1:0]   acc_n_s;
    logic [LEN_W-1:0]    cnt_n_s;
    logic                hit_s;
    logic [CHAR_W-1:0]   hit_char_s;
    logic                match_s;
    logic                err_s;
    logic [CODE_W-1:0]   acc_next_s;
    logic [LEN_W-1:0]    cnt_next_s;

    // Whether any slot remains valid after this cycle's table write.
    always_comb begin
        any_valid_next_s = 1'b0;
        for (int i = 0; i < NUM_CHAR; i++) begin
            if (tbl_valid && (tbl_slot == SLOT_W'(i))) begin
                any_valid_next_s = any_valid_next_s | (tbl_len != '0);
            end else begin
                any_valid_next_s = any_valid_next_s | slot_valid_r[i];
            end
        end
    end

    // Next-state logic: DECODE exactly while the table holds a valid slot.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (!tbl_clr && tbl_valid && (tbl_len != '0)) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_DECODE: begin
                if (tbl_clr || !any_valid_next_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_DECODE;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Bit compare against the pre-write table; lowest matching slot wins.
    always_comb begin
        take_bit_s = (state_r == ST_DECODE) && bit_valid && !tbl_clr && !flush;
        acc_n_s    = {acc_r[CODE_W-2:0], bit_in};
        cnt_n_s    = cnt_r + LEN_W'(1);
        hit_s      = 1'b0;
        hit_char_s = '0;
        for (int i = NUM_CHAR - 1; i >= 0; i--) begin
            if (slot_valid_r[i] && (len_r[i] == cnt_n_s) &&
                (((code_r[i] ^ acc_n_s) & len_mask(len_r[i])) == '0)) begin
                hit_s      = 1'b1;
                hit_char_s = char_r[i];
            end else begin
                hit_s      = hit_s;
            end
        end
        match_s = take_bit_s && hit_s;
        err_s   = take_bit_s && !hit_s && (cnt_n_s == MAX_CNT);
    end

    // Accumulator update; any terminating or discarding event restarts the codeword.
    always_comb begin
        acc_next_s = acc_r;
        cnt_next_s = cnt_r;
        if (tbl_clr || flush || match_s || err_s || (state_s == ST_EMPTY)) begin
            acc_next_s = '0;
            cnt_next_s = '0;
        end else if (take_bit_s) begin
            acc_next_s = acc_n_s;
            cnt_next_s = cnt_n_s;
        end else begin
            acc_next_s = acc_r;
            cnt_next_s = cnt_r;
        end
    end

    // Code table storage; tbl_clr overrides a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHAR; i++) begin
                slot_valid_r[i] <= 1'b0;
                char_r[i]       <= '0;
                code_r[i]       <= '0;
                len_r[i]        <= '0;
            end
        end else if (tbl_clr) begin
            for (int i = 0; i < NUM_CHAR; i++) begin
                slot_valid_r[i] <= 1'b0;
            end
        end else if (tbl_valid) begin
            slot_valid_r[tbl_slot] <= (tbl_len != '0);
            char_r[tbl_slot]       <= tbl_char;
            code_r[tbl_slot]       <= tbl_code;
            len_r[tbl_slot]        <= tbl_len;
        end
    end

    // State, accumulator and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_char_r  <= '0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_next_s;
            cnt_r       <= cnt_next_s;
            out_valid_r <= match_s;
            out_char_r  <= match_s ? hit_char_s : '0;
            err_r       <= err_s;
            busy_r      <= (cnt_next_s != '0);
        end
    end

    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;
    assign err       = err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_huff_bit_decoder.sv
// Scenario-driven bench for huff_bit_decoder: a per-cycle scoreboard queue
// holds the expected out_valid/out_char/err for every driven cycle.
module tb_huff_bit_decoder;

    logic       clk;
    logic       rst;
    logic       tbl_valid;
    logic [2:0] tbl_slot;
    logic [3:0] tbl_char;
    logic [6:0] tbl_code;
    logic [2:0] tbl_len;
    logic       tbl_clr;
    logic       flush;
    logic       bit_valid;
    logic       bit_in;
    logic       out_valid;
    logic [3:0] out_char;
    logic       err;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic       v;
        logic       e;
        logic [3:0] ch;
    } exp_t;

    exp_t exp_q[$];

    huff_bit_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_valid (tbl_valid),
        .tbl_slot  (tbl_slot),
        .tbl_char  (tbl_char),
        .tbl_code  (tbl_code),
        .tbl_len   (tbl_len),
        .tbl_clr   (tbl_clr),
        .flush     (flush),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .out_valid (out_valid),
        .out_char  (out_char),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One clock of whatever inputs the caller set; the expectation is queued, then popped and checked.
    task automatic step(input string tag, input logic ev, input logic ee, input logic [3:0] ec);
        exp_t e;
        e.v  = ev;
        e.e  = ee;
        e.ch = ev ? ec : 4'd0;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++;
        if (out_valid !== e.v) $display("FAIL %s out_valid got %b exp %b", tag, out_valid, e.v);
        else pass_cnt++;
        total_cnt++;
        if (out_char !== e.ch) $display("FAIL %s out_char got %0d exp %0d", tag, out_char, e.ch);
        else pass_cnt++;
        total_cnt++;
        if (err !== e.e) $display("FAIL %s err got %b exp %b", tag, err, e.e);
        else pass_cnt++;
    endtask

    task automatic drive_bit(input string tag, input logic b, input logic ev, input logic ee,
                             input logic [3:0] ec);
        bit_valid = 1'b1;
        bit_in    = b;
        step(tag, ev, ee, ec);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic load(input logic [2:0] slot, input logic [3:0] ch, input logic [6:0] code,
                        input logic [2:0] len);
        tbl_valid = 1'b1;
        tbl_slot  = slot;
        tbl_char  = ch;
        tbl_code  = code;
        tbl_len   = len;
        step("load", 1'b0, 1'b0, 4'd0);
        tbl_valid = 1'b0;
    endtask

    task automatic clr_table();
        tbl_clr = 1'b1;
        step("clr", 1'b0, 1'b0, 4'd0);
        tbl_clr = 1'b0;
    endtask

    task automatic load_t1();
        clr_table();
        load(3'd0, 4'd1, 7'b0000000, 3'd1);
        load(3'd1, 4'd2, 7'b0000010, 3'd2);
        load(3'd2, 4'd3, 7'b0000110, 3'd3);
        load(3'd3, 4'd4, 7'b0000111, 3'd3);
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({out_valid, out_char, err, busy} !== 7'd0)
            $display("FAIL reset outputs got %b exp 0000000", {out_valid, out_char, err, busy});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        drive_bit("empty_ignored", 1'b0, 1'b0, 1'b0, 4'd0);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL empty_busy got %b exp 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        load_t1();
        drive_bit("t1_b1", 1'b0, 1'b1, 1'b0, 4'd1);
        drive_bit("t1_b2", 1'b1, 1'b0, 1'b0, 4'd0);
        drive_bit("t1_b3", 1'b0, 1'b1, 1'b0, 4'd2);
        drive_bit("t1_b4", 1'b1, 1'b0, 1'b0, 4'd0);
        drive_bit("t1_b5", 1'b1, 1'b0, 1'b0, 4'd0);
        drive_bit("t1_b6", 1'b1, 1'b1, 1'b0, 4'd4);
    endtask

    task automatic test_err();
        clr_table();
        load(3'd0, 4'd5, 7'b0000000, 3'd7);
        for (int i = 0; i < 7; i++) drive_bit("t2_ones", 1'b1, 1'b0, (i == 6), 4'd0);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t2_busy_after_err got %b exp 0", busy);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) drive_bit("t2_zeros", 1'b0, (i == 6), 1'b0, 4'd5);
    endtask

    task automatic test_flush();
        load_t1();
        drive_bit("t3_b1", 1'b1, 1'b0, 1'b0, 4'd0);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL t3_busy_set got %b exp 1", busy);
        else pass_cnt++;
        drive_bit("t3_b2", 1'b1, 1'b0, 1'b0, 4'd0);
        flush = 1'b1;
        step("t3_flush", 1'b0, 1'b0, 4'd0);
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t3_busy_flush got %b exp 0", busy);
        else pass_cnt++;
        drive_bit("t3_b3", 1'b0, 1'b1, 1'b0, 4'd1);
    endtask

    task automatic test_priority_slot();
        clr_table();
        load(3'd5, 4'd9, 7'b0000001, 3'd2);
        load(3'd2, 4'd6, 7'b0000001, 3'd2);
        drive_bit("t4_b1", 1'b0, 1'b0, 1'b0, 4'd0);
        drive_bit("t4_b2", 1'b1, 1'b1, 1'b0, 4'd6);
    endtask

    task automatic test_gap_and_clr();
        load_t1();
        drive_bit("t5_b1", 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step("t5_idle", 1'b0, 1'b0, 4'd0);
        drive_bit("t5_b2", 1'b0, 1'b1, 1'b0, 4'd2);
        clr_table();
        drive_bit("t5_empty0", 1'b0, 1'b0, 1'b0, 4'd0);
        drive_bit("t5_empty1", 1'b1, 1'b0, 1'b0, 4'd0);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t5_busy_empty got %b exp 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        load_t1();
        for (int i = 0; i < 3; i++) drive_bit("b2b_zero", 1'b0, 1'b1, 1'b0, 4'd1);
        drive_bit("b2b_a", 1'b1, 1'b0, 1'b0, 4'd0);
        drive_bit("b2b_b", 1'b0, 1'b1, 1'b0, 4'd2);
        drive_bit("b2b_c", 1'b0, 1'b1, 1'b0, 4'd1);
    endtask

    task automatic test_simultaneous();
        load_t1();
        // Bit and rewrite of the slot it completes: compare sees the old char.
        drive_bit("sim_b1", 1'b1, 1'b0, 1'b0, 4'd0);
        tbl_valid = 1'b1; tbl_slot = 3'd1; tbl_char = 4'd7; tbl_code = 7'b0000010; tbl_len = 3'd2;
        drive_bit("sim_old_tbl", 1'b0, 1'b1, 1'b0, 4'd2);
        tbl_valid = 1'b0;
        drive_bit("sim_new_a", 1'b1, 1'b0, 1'b0, 4'd0);
        drive_bit("sim_new_b", 1'b0, 1'b1, 1'b0, 4'd7);
        // Flush drops the bit but the write still lands.
        flush = 1'b1;
        tbl_valid = 1'b1; tbl_slot = 3'd0; tbl_char = 4'd8; tbl_code = 7'b0000000; tbl_len = 3'd1;
        drive_bit("sim_flush_drop", 1'b0, 1'b0, 1'b0, 4'd0);
        flush = 1'b0;
        tbl_valid = 1'b0;
        drive_bit("sim_flush_write", 1'b0, 1'b1, 1'b0, 4'd8);
        // tbl_clr drops the bit and ignores the write.
        tbl_clr = 1'b1;
        tbl_valid = 1'b1; tbl_slot = 3'd4; tbl_char = 4'd3; tbl_code = 7'b0000001; tbl_len = 3'd1;
        drive_bit("sim_clr_drop", 1'b1, 1'b0, 1'b0, 4'd0);
        tbl_clr = 1'b0;
        tbl_valid = 1'b0;
        drive_bit("sim_clr_nowrite", 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_async_reset();
        load_t1();
        drive_bit("t6_b1", 1'b1, 1'b0, 1'b0, 4'd0);
        drive_bit("t6_b2", 1'b1, 1'b0, 1'b0, 4'd0);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL t6_busy got %b exp 1", busy);
        else pass_cnt++;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_char} !== 5'b1_0011)
            $display("FAIL t6_pending got %b exp 10011", {out_valid, out_char});
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_char, err, busy} !== 7'd0)
            $display("FAIL t6_async_clear got %b exp 0000000", {out_valid, out_char, err, busy});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        drive_bit("t6_ignored0", 1'b0, 1'b0, 1'b0, 4'd0);
        drive_bit("t6_ignored1", 1'b1, 1'b0, 1'b0, 4'd0);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t6_busy_empty got %b exp 0", busy);
        else pass_cnt++;
        load(3'd0, 4'd1, 7'b0000000, 3'd1);
        drive_bit("t6_reload", 1'b0, 1'b1, 1'b0, 4'd1);
    endtask

    initial begin
        rst       = 1'b1;
        tbl_valid = 1'b0;
        tbl_slot  = 3'd0;
        tbl_char  = 4'd0;
        tbl_code  = 7'd0;
        tbl_len   = 3'd0;
        tbl_clr   = 1'b0;
        flush     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        test_reset();
        test_basic();
        test_err();
        test_flush();
        test_priority_slot();
        test_gap_and_clr();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
